// File: rtl/v_prbs_gen_132_if.sv
// Handshake/data bundle for the PRBS31 burst generator.
// V_PRBS_GEN_ERR_INJ_EN adds the single-bit error-injection controls.
interface v_prbs_gen_132_if #(
  parameter int WIDTH = 132
);
  logic             start;
  logic [31:0]      num_words;
`ifdef V_PRBS_GEN_ERR_INJ_EN
  logic [31:0]      inj_word;
  logic [7:0]       inj_bit;
`endif
  logic [WIDTH-1:0] bit_tx;
  logic             tx_valid;
  logic [WIDTH-1:0] bit_ref;
  logic             ref_valid;
  logic             busy;
  logic             done;
  logic [31:0]      word_cnt;

  modport master (
    output start,
    output num_words,
`ifdef V_PRBS_GEN_ERR_INJ_EN
    output inj_word,
    output inj_bit,
`endif
    input  bit_tx,
    input  tx_valid,
    input  bit_ref,
    input  ref_valid,
    input  busy,
    input  done,
    input  word_cnt
  );

  modport slave (
    input  start,
    input  num_words,
`ifdef V_PRBS_GEN_ERR_INJ_EN
    input  inj_word,
    input  inj_bit,
`endif
    output bit_tx,
    output tx_valid,
    output bit_ref,
    output ref_valid,
    output busy,
    output done,
    output word_cnt
  );
endinterface

// File: rtl/v_prbs_gen_132.sv
// PRBS31 (x^31+x^28+1) burst source: WIDTH bits per clock on bit_tx, REF_DELAY-delayed copy on bit_ref.
// Optional V_PRBS_GEN_ERR_INJ_EN flips one chosen bit of one chosen word on bit_tx only.
module v_prbs_gen_132 #(
  parameter int          WIDTH     = 132,
  parameter int          REF_DELAY = 2,
  parameter logic [30:0] SEED      = 31'h7FFFFFFF
) (
  input  logic               clk,
  input  logic               rst,
  v_prbs_gen_132_if.slave    bus
);

  localparam logic [30:0] LFSR_INIT  = (SEED == 31'd0) ? 31'h7FFFFFFF : SEED;
  localparam logic [4:0]  DRAIN_LAST = 5'(REF_DELAY - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [30:0]      r_lfsr;
  logic [30:0]      w_lfsr_next;
  logic [WIDTH-1:0] w_word;
  logic [31:0]      r_num_words;
  logic [31:0]      r_word_cnt;
  logic [4:0]       r_drain_cnt;
  logic [WIDTH-1:0] r_tx_word;
  logic             r_tx_valid;
  logic [WIDTH-1:0] r_ref_data [REF_DELAY];
  logic             r_ref_vld  [REF_DELAY];
  logic             w_last_word;

  // WIDTH serial LFSR steps unrolled; bit 0 is the earliest emitted bit
  always_comb begin
    logic [30:0] s;
    logic        n;
    s      = r_lfsr;
    w_word = '0;
    for (int k = 0; k < WIDTH; k++) begin
      n         = s[30] ^ s[27];
      w_word[k] = n;
      s         = {s[29:0], n};
    end
    w_lfsr_next = s;
  end

  assign w_last_word = (r_word_cnt == r_num_words - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = (bus.num_words != 32'd0) ? S_RUN : S_DONE;
      S_RUN:   if (w_last_word) w_state_next = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef V_PRBS_GEN_ERR_INJ_EN
  logic [31:0]      r_inj_word;
  logic [7:0]       r_inj_bit;
  logic [WIDTH-1:0] r_inj_mask;
  logic             w_inj_hit;

  assign w_inj_hit = (r_inj_word != 32'd0) && (r_word_cnt + 32'd1 == r_inj_word) &&
                     ({24'd0, r_inj_bit} < 32'(WIDTH));

  // Mask is registered beside the clean word so the reference path never sees it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inj_word <= '0;
      r_inj_bit  <= '0;
      r_inj_mask <= '0;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_inj_word <= bus.inj_word;
        r_inj_bit  <= bus.inj_bit;
      end
      if (r_state == S_RUN && w_inj_hit) r_inj_mask <= WIDTH'(1) << r_inj_bit;
      else                               r_inj_mask <= '0;
    end
  end

  assign bus.bit_tx = r_tx_word ^ r_inj_mask;
`else
  assign bus.bit_tx = r_tx_word;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr      <= LFSR_INIT;
      r_num_words <= '0;
      r_word_cnt  <= '0;
      r_drain_cnt <= '0;
      r_tx_word   <= '0;
      r_tx_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_num_words <= bus.num_words;
            r_word_cnt  <= '0;
            r_lfsr      <= LFSR_INIT;
          end
        end
        S_RUN: begin
          r_tx_word   <= w_word;
          r_tx_valid  <= 1'b1;
          r_word_cnt  <= r_word_cnt + 32'd1;
          r_lfsr      <= w_lfsr_next;
          r_drain_cnt <= '0;
        end
        S_DRAIN: begin
          r_tx_word   <= '0;
          r_tx_valid  <= 1'b0;
          r_drain_cnt <= r_drain_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Reference delay line runs freely; it flushes to zero between bursts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REF_DELAY; i++) begin
        r_ref_data[i] <= '0;
        r_ref_vld[i]  <= 1'b0;
      end
    end else begin
      r_ref_data[0] <= r_tx_word;
      r_ref_vld[0]  <= r_tx_valid;
      for (int i = 1; i < REF_DELAY; i++) begin
        r_ref_data[i] <= r_ref_data[i-1];
        r_ref_vld[i]  <= r_ref_vld[i-1];
      end
    end
  end

  assign bus.tx_valid  = r_tx_valid;
  assign bus.bit_ref   = r_ref_data[REF_DELAY-1];
  assign bus.ref_valid = r_ref_vld[REF_DELAY-1];
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_v_prbs_gen_132.sv
// Scoreboard bench for v_prbs_gen_132: stimulus pushes expected words/burst summaries,
// a negedge monitor pops and compares whenever the DUT presents tx/ref words or done.
module tb_v_prbs_gen_132;
  localparam int          WIDTH     = 132;
  localparam int          REF_DELAY = 2;
  localparam logic [30:0] SEED      = 31'h7FFFFFFF;

  typedef struct {
    int unsigned cnt;
    int unsigned ntx;
    int unsigned nref;
    int unsigned nbusy;
  } done_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic [WIDTH-1:0] exp_tx_q  [$];
  logic [WIDTH-1:0] exp_ref_q [$];
  done_t            exp_done_q[$];

  v_prbs_gen_132_if #(.WIDTH(WIDTH)) bus ();

  v_prbs_gen_132 #(.WIDTH(WIDTH), .REF_DELAY(REF_DELAY), .SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not seen / nothing expected", nm);
  endtask

  // Serial PRBS31 reference: one bit per step, bit 0 of the word first
  function automatic logic [WIDTH-1:0] model_word(inout logic [30:0] s);
    logic [WIDTH-1:0] w;
    logic             n;
    w = '0;
    for (int k = 0; k < WIDTH; k++) begin
      n    = s[30] ^ s[27];
      w[k] = n;
      s    = {s[29:0], n};
    end
    return w;
  endfunction

  task automatic push_burst(input int unsigned n, input int unsigned iw, input int unsigned ib);
    logic [30:0]      s;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] m;
    done_t            d;
    s = SEED;
    for (int unsigned k = 1; k <= n; k++) begin
      w = model_word(s);
      m = '0;
      if (iw != 0 && k == iw && ib < WIDTH) m[ib] = 1'b1;
      exp_tx_q.push_back(w ^ m);
      exp_ref_q.push_back(w);
    end
    d.cnt   = n;
    d.ntx   = n;
    d.nref  = n;
    d.nbusy = (n == 0) ? 1 : n + REF_DELAY + 1;
    exp_done_q.push_back(d);
  endtask

  task automatic wait_done(input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) miss("done_timeout");
  endtask

  task automatic after_done(input int unsigned n);
    @(negedge clk);
    chk("idle_busy", WIDTH'(bus.busy), WIDTH'(0));
    chk("idle_ref_valid", WIDTH'(bus.ref_valid), WIDTH'(0));
    chk("idle_bit_ref", bus.bit_ref, WIDTH'(0));
    chk("word_cnt_hold", WIDTH'(bus.word_cnt), WIDTH'(n));
  endtask

  task automatic issue_start(input int unsigned n, input int unsigned iw, input int unsigned ib);
    push_burst(n, iw, ib);
    bus.start     = 1'b1;
    bus.num_words = n;
`ifdef V_PRBS_GEN_ERR_INJ_EN
    bus.inj_word  = iw;
    bus.inj_bit   = 8'(ib);
`endif
    @(negedge clk);
    bus.start     = 1'b0;
    bus.num_words = 32'hDEAD_BEEF;
  endtask

  task automatic run_burst(input int unsigned n, input int unsigned iw, input int unsigned ib);
    issue_start(n, iw, ib);
    wait_done(int'(n) + 40);
    after_done(n);
  endtask

  // Monitor / scoreboard
  int unsigned m_ntx, m_nref, m_nbusy;
  bit          prev_done;
  always @(negedge clk) begin
    if (rst) begin
      m_ntx = 0; m_nref = 0; m_nbusy = 0; prev_done = 1'b0;
    end else begin
      if (bus.busy) m_nbusy++;
      if (bus.tx_valid) begin
        if (m_ntx == 0) chk("first_word_low29", WIDTH'(bus.bit_tx[28:0]), WIDTH'(29'h1000_0000));
        if (exp_tx_q.size() == 0) miss("tx_unexpected");
        else chk("tx_word", bus.bit_tx, exp_tx_q.pop_front());
        m_ntx++;
      end
      if (bus.ref_valid) begin
        if (exp_ref_q.size() == 0) miss("ref_unexpected");
        else chk("ref_word", bus.bit_ref, exp_ref_q.pop_front());
        m_nref++;
      end
      if (prev_done) chk("done_one_clock", WIDTH'(bus.done), WIDTH'(0));
      if (bus.done) begin
        if (exp_done_q.size() == 0) miss("done_unexpected");
        else begin
          done_t d;
          d = exp_done_q.pop_front();
          chk("done_word_cnt", WIDTH'(bus.word_cnt), WIDTH'(d.cnt));
          chk("tx_valid_cycles", WIDTH'(m_ntx), WIDTH'(d.ntx));
          chk("ref_valid_cycles", WIDTH'(m_nref), WIDTH'(d.nref));
          chk("busy_cycles", WIDTH'(m_nbusy), WIDTH'(d.nbusy));
        end
        $display("burst: word_cnt=%0d tx=%0d ref=%0d busy=%0d", bus.word_cnt, m_ntx, m_nref, m_nbusy);
        m_ntx = 0; m_nref = 0; m_nbusy = 0;
      end
      prev_done = bus.done;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      WIDTH'(bus.busy), WIDTH'(0));
    chk({tag, "_done"},      WIDTH'(bus.done), WIDTH'(0));
    chk({tag, "_tx_valid"},  WIDTH'(bus.tx_valid), WIDTH'(0));
    chk({tag, "_bit_tx"},    bus.bit_tx, WIDTH'(0));
    chk({tag, "_ref_valid"}, WIDTH'(bus.ref_valid), WIDTH'(0));
    chk({tag, "_bit_ref"},   bus.bit_ref, WIDTH'(0));
    chk({tag, "_word_cnt"},  WIDTH'(bus.word_cnt), WIDTH'(0));
  endtask

  initial begin
    bit found;
    n_chk         = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.num_words = '0;
`ifdef V_PRBS_GEN_ERR_INJ_EN
    bus.inj_word  = '0;
    bus.inj_bit   = '0;
`endif
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single word, then a 5-word burst, then an empty burst
    run_burst(1, 0, 0);
    run_burst(5, 0, 0);
    run_burst(0, 0, 0);

    // Start re-pulsed with a different length while busy: must be ignored
    issue_start(4, 0, 0);
    bus.num_words = 32'd7;
    repeat (3) begin
      bus.start = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_done(40);
    after_done(4);

    // Asynchronous reset on word 3 of a 10-word burst
    issue_start(10, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.tx_valid && bus.word_cnt == 32'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) miss("word3_timeout");
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    exp_tx_q.delete();
    exp_ref_q.delete();
    exp_done_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_burst(2, 0, 0);

`ifdef V_PRBS_GEN_ERR_INJ_EN
    run_burst(3, 2, 131);
    run_burst(3, 0, 131);
`endif

    chk("tx_queue_drained",   WIDTH'(exp_tx_q.size()), WIDTH'(0));
    chk("ref_queue_drained",  WIDTH'(exp_ref_q.size()), WIDTH'(0));
    chk("done_queue_drained", WIDTH'(exp_done_q.size()), WIDTH'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
